// File: rtl/usb_cdc_arb_pkg.sv
// Shared types and width helpers for the USB CDC IN arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package usb_cdc_arb_pkg;

    // Arbiter FSM states: IDLE picks the next requester, GRANT forwards its bytes.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int BYTE_W = 8;

    // Counter/index width for a modulus of n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Widths for the default configuration (MAX_BURST=64, TIMEOUT_CYCLES=1024).
    localparam int DEF_BURST_W = cnt_w(64);
    localparam int DEF_STALL_W = cnt_w(1024);

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first set request at or after i_ptr, cyclically.
// Latency: purely combinational.
// Backpressure: none; o_hit low when no request is set.
//
// Ports:
//   i_req  - request vector, bit k = requester k
//   i_ptr  - index where the cyclic search starts (must be < NUM_REQ)
//   o_pick - one-hot selected requester, 0 when no hit
//   o_hit  - at least one request was set
module rr_priority_picker
    import usb_cdc_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = cnt_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic               o_hit
);

    logic [PTR_W-1:0] w_j;

    always_comb begin
        o_pick = '0;
        o_hit  = 1'b0;
        w_j    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_j = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!o_hit && i_req[w_j]) begin
                o_pick[w_j] = 1'b1;
                o_hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_cdc_in_arbiter.sv
// Round-robin arbiter sharing the USB CDC IN byte channel among NUM_REQ byte streams.
// Latency: valid in IDLE cycle N -> grant at N+1 -> in_valid_o at N+2; then 1 byte/cycle.
// Backpressure: req_ready_o only for the granted source, when the output register is empty or draining.
//
// Ports:
//   clk_i, reset_i             - clock, synchronous active-high reset
//   req_data_i/valid/last      - per-requester byte streams (byte k at [8k+7:8k])
//   req_ready_o                - per-requester accept, only the granted bit can be high
//   in_data_o/valid, in_ready_i- registered byte stream toward the CDC IN channel
//   grant_o                    - one-hot current grant, 0 in IDLE
//   timeout_o                  - one-cycle pulse on stall-timeout release
// Optional: define USB_ARB_TIMEOUT_EN to release a grant stalled for TIMEOUT_CYCLES cycles;
// without it the grant is held until last byte or burst limit and timeout_o stays 0.
module usb_cdc_in_arbiter
    import usb_cdc_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int MAX_BURST      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [BYTE_W-1:0]         in_data_o,
    output logic                      in_valid_o,
    input  logic                      in_ready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      timeout_o
);

    localparam int PTR_W   = cnt_w(NUM_REQ);
    localparam int BURST_W = cnt_w(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0]   IDX_LAST   = PTR_W'(NUM_REQ - 1);

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("usb_cdc_in_arbiter: NUM_REQ must be 2..8");
    end
    if (MAX_BURST < 2 || MAX_BURST > 256 || (MAX_BURST & (MAX_BURST - 1)) != 0) begin : g_bad_burst
        $error("usb_cdc_in_arbiter: MAX_BURST must be a power of two in 2..256");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("usb_cdc_in_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    // State
    arb_state_t           r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]     r_idx;      // index of the granted requester
    logic [PTR_W-1:0]     r_ptr;      // round-robin search start
    logic [BURST_W-1:0]   r_burst;
    logic [BYTE_W-1:0]    r_out_dat;
    logic                 r_out_vld;
    logic                 r_timeout;

    // Next-state and datapath wires
    arb_state_t           w_state_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [PTR_W-1:0]     w_idx_nxt;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [BURST_W-1:0]   w_burst_nxt;
    logic [BYTE_W-1:0]    w_out_dat_nxt;
    logic                 w_out_vld_nxt;
    logic                 w_release;

    logic [NUM_REQ-1:0]   w_pick;
    logic                 w_hit;
    logic [PTR_W-1:0]     w_pick_idx;
    logic                 w_out_free;
    logic [NUM_REQ-1:0]   w_req_rdy;
    logic                 w_accept;
    logic                 w_sel_vld;
    logic                 w_sel_last;
    logic [BYTE_W-1:0]    w_sel_dat;
    logic                 w_tmo_fire;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_req  (req_valid_i),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_hit  (w_hit)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = PTR_W'(i);
            end
        end
    end

    // The output register can take a new byte if empty or being consumed this cycle.
    assign w_out_free = ~r_out_vld | in_ready_i;
    assign w_req_rdy  = (r_state == GRANT && w_out_free) ? r_grant : '0;
    assign w_accept   = |(req_valid_i & w_req_rdy);
    assign w_sel_vld  = req_valid_i[r_idx];
    assign w_sel_last = req_last_i[r_idx];
    assign w_sel_dat  = req_data_i[int'(r_idx)*BYTE_W +: BYTE_W];

`ifdef USB_ARB_TIMEOUT_EN
    localparam int STALL_W = cnt_w(TIMEOUT_CYCLES);
    logic [STALL_W-1:0] r_stall;

    // Counts consecutive GRANT cycles in which the granted source has no byte.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stall <= '0;
        end else if (r_state != GRANT || w_sel_vld || w_release) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign w_tmo_fire = (r_state == GRANT) && !w_sel_vld &&
                        (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_fire = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
        w_burst_nxt   = r_burst;
        w_out_dat_nxt = r_out_dat;
        w_out_vld_nxt = r_out_vld;
        w_release     = 1'b0;

        case (r_state)
            IDLE: begin
                // A byte left over from the previous grant still drains.
                if (r_out_vld && in_ready_i) begin
                    w_out_vld_nxt = 1'b0;
                end
                if (w_hit) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_pick;
                    w_idx_nxt   = w_pick_idx;
                    w_burst_nxt = '0;
                end
            end
            GRANT: begin
                if (w_accept) begin
                    w_out_dat_nxt = w_sel_dat;
                    w_out_vld_nxt = 1'b1;
                    w_burst_nxt   = r_burst + 1'b1;
                    if (w_sel_last || r_burst == BURST_LAST) begin
                        w_release = 1'b1;
                    end
                end else if (r_out_vld && in_ready_i) begin
                    w_out_vld_nxt = 1'b0;
                end
                if (w_tmo_fire) begin
                    w_release = 1'b1;
                end
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_burst_nxt = '0;
                    w_ptr_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_burst   <= '0;
            r_out_dat <= '0;
            r_out_vld <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_burst   <= w_burst_nxt;
            r_out_dat <= w_out_dat_nxt;
            r_out_vld <= w_out_vld_nxt;
            r_timeout <= w_tmo_fire;
        end
    end

    assign req_ready_o = w_req_rdy;
    assign in_data_o   = r_out_dat;
    assign in_valid_o  = r_out_vld;
    assign grant_o     = r_grant;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_usb_cdc_in_arbiter.sv
// Directed self-checking bench for usb_cdc_in_arbiter with an output-byte scoreboard.
// Latency: n/a (testbench).
// Backpressure: in_ready_i driven fixed or toggling every 5 cycles.
`timescale 1ns/1ps
module tb_usb_cdc_in_arbiter;

    localparam int NREQ = 3;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [7:0]        in_data_o;
    logic              in_valid_o;
    logic              in_ready_i;
    logic [NREQ-1:0]   grant_o;
    logic              timeout_o;

    always #5 clk_i = ~clk_i;

    usb_cdc_in_arbiter #(
        .NUM_REQ        (NREQ),
        .MAX_BURST      (64),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .in_data_o   (in_data_o),
        .in_valid_o  (in_valid_o),
        .in_ready_i  (in_ready_i),
        .grant_o     (grant_o),
        .timeout_o   (timeout_o)
    );

    int         npass = 0;
    int         nfail = 0;
    int         cyc   = 0;
    bit         tog_mode  = 1'b0;
    bit         rdy_fixed = 1'b1;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    logic [8:0] src_q [NREQ][$];   // per-requester {last, data} to offer
    logic [7:0] sb_q [$];          // expected output byte order

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_src(input int k, input logic [7:0] d, input logic last);
        src_q[k].push_back({last, d});
    endtask

    task automatic expect_byte(input logic [7:0] d);
        sb_q.push_back(d);
    endtask

    task automatic drive();
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (src_q[k].size() > 0) begin
                req_valid_i[k]       = 1'b1;
                req_last_i[k]        = src_q[k][0][8];
                req_data_i[k*8 +: 8] = src_q[k][0][7:0];
            end
        end
        in_ready_i = tog_mode ? (((cyc / 5) % 2) == 0) : rdy_fixed;
    endtask

    // Called on the falling edge: inputs and outputs are settled for this cycle.
    task automatic monitor();
        logic [7:0] exp_d;
        chk("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
        if (prev_stall) begin
            chk("stall_stable", 32'({in_valid_o, in_data_o}), 32'({1'b1, prev_dat}));
        end
        if (in_valid_o && !in_ready_i) begin
            chk("ready_when_full", 32'(req_ready_o), 32'd0);
        end
        if (!reset_i) begin
            for (int k = 0; k < NREQ; k++) begin
                if (req_valid_i[k] && req_ready_o[k] && src_q[k].size() > 0) begin
                    void'(src_q[k].pop_front());
                end
            end
            if (in_valid_o && in_ready_i) begin
                chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_d = sb_q.pop_front();
                    chk("out_data", 32'(in_data_o), 32'(exp_d));
                end
            end
        end
        prev_stall = in_valid_o && !in_ready_i && !reset_i;
        prev_dat   = in_data_o;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        drive();
        @(negedge clk_i);
        monitor();
    endtask

    task automatic clear_all();
        for (int k = 0; k < NREQ; k++) src_q[k].delete();
        sb_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clear_all();
        step();
        step();
        reset_i = 1'b0;
    endtask

    // Step until all stimulus is consumed and every expected byte seen, bounded.
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
                src_q[2].size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        reset_i     = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        in_ready_i  = 1'b1;

        // Reset state
        do_reset();
        chk("rst_in_valid", 32'(in_valid_o), 32'd0);
        chk("rst_in_data", 32'(in_data_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);

        // Single requester 1, three-byte packet, latency profile
        add_src(1, 8'h11, 1'b0); add_src(1, 8'h22, 1'b0); add_src(1, 8'h33, 1'b1);
        expect_byte(8'h11); expect_byte(8'h22); expect_byte(8'h33);
        step();
        chk("t1_grant_n", 32'(grant_o), 32'd0);
        step();
        chk("t1_grant_n1", 32'(grant_o), 32'b010);
        chk("t1_ready_n1", 32'(req_ready_o), 32'b010);
        chk("t1_vld_n1", 32'(in_valid_o), 32'd0);
        step();
        chk("t1_vld_n2", 32'(in_valid_o), 32'd1);
        chk("t1_dat_n2", 32'(in_data_o), 32'h11);
        drain("t1_drain", 20);
        chk("t1_grant_after_last", 32'(grant_o), 32'd0);

        // Pointer now 2: requesters 0 and 2 together -> 2 wins first
        add_src(0, 8'h40, 1'b1); add_src(2, 8'h42, 1'b1);
        expect_byte(8'h42); expect_byte(8'h40);
        step();
        step();
        chk("t1_ptr2_grant", 32'(grant_o), 32'b100);
        drain("t1_ptr2_drain", 20);

        // Requesters 0 and 2 with 2-byte packets from reset: no interleave, one idle gap
        do_reset();
        add_src(0, 8'hA0, 1'b0); add_src(0, 8'hA1, 1'b1);
        add_src(2, 8'hC0, 1'b0); add_src(2, 8'hC1, 1'b1);
        expect_byte(8'hA0); expect_byte(8'hA1); expect_byte(8'hC0); expect_byte(8'hC1);
        step();
        step();
        chk("t2_grant0", 32'(grant_o), 32'b001);
        step();
        chk("t2_grant0_hold", 32'(grant_o), 32'b001);
        step();
        chk("t2_idle_gap", 32'(grant_o), 32'd0);
        step();
        chk("t2_grant2", 32'(grant_o), 32'b100);
        drain("t2_drain", 20);

        // Burst limit: 70 bytes from 0 without last, requester 1 waiting
        do_reset();
        for (int i = 0; i < 70; i++) add_src(0, 8'(i), 1'b0);
        add_src(1, 8'hB0, 1'b0); add_src(1, 8'hB1, 1'b1);
        for (int i = 0; i < 64; i++) expect_byte(8'(i));
        expect_byte(8'hB0); expect_byte(8'hB1);
        for (int i = 64; i < 70; i++) expect_byte(8'(i));
        drain("t3_drain", 300);
        step();
        step();
        chk("t3_grant_held", 32'(grant_o), 32'b001);

        // Output backpressure toggling every 5 cycles
        do_reset();
        tog_mode = 1'b1;
        add_src(2, 8'hD0, 1'b0); add_src(2, 8'hD1, 1'b0);
        add_src(2, 8'hD2, 1'b0); add_src(2, 8'hD3, 1'b1);
        expect_byte(8'hD0); expect_byte(8'hD1); expect_byte(8'hD2); expect_byte(8'hD3);
        drain("t4_drain", 100);
        tog_mode = 1'b0;
        step();
        chk("t4_grant_released", 32'(grant_o), 32'd0);

        // Reset mid-packet with a pending output byte
        do_reset();
        rdy_fixed = 1'b1;
        add_src(1, 8'h51, 1'b1);
        expect_byte(8'h51);
        drain("t5_pre_drain", 20);
        rdy_fixed = 1'b0;
        for (int i = 0; i < 4; i++) add_src(1, 8'(8'h60 + i), (i == 3));
        for (int i = 0; i < 4; i++) step();
        chk("t5_pending", 32'(in_valid_o), 32'd1);
        reset_i = 1'b1;
        clear_all();
        step();
        chk("t5_rst_in_valid", 32'(in_valid_o), 32'd0);
        chk("t5_rst_in_data", 32'(in_data_o), 32'd0);
        chk("t5_rst_grant", 32'(grant_o), 32'd0);
        chk("t5_rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("t5_rst_timeout", 32'(timeout_o), 32'd0);
        reset_i   = 1'b0;
        rdy_fixed = 1'b1;
        add_src(1, 8'h71, 1'b1); add_src(2, 8'h72, 1'b1);
        expect_byte(8'h71); expect_byte(8'h72);
        step();
        step();
        chk("t5_ptr_reset", 32'(grant_o), 32'b010);
        drain("t5_drain", 20);

`ifdef USB_ARB_TIMEOUT_EN
        // Stall timeout: requester 0 sends one byte without last, then goes quiet
        do_reset();
        add_src(0, 8'h81, 1'b0); add_src(1, 8'h91, 1'b1);
        expect_byte(8'h81); expect_byte(8'h91);
        step();
        found = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (timeout_o) begin
                found = i;
                break;
            end
        end
        chk("t6_timeout_cycle", 32'(found), 32'd18);
        chk("t6_grant_released", 32'(grant_o), 32'd0);
        step();
        chk("t6_timeout_pulse", 32'(timeout_o), 32'd0);
        chk("t6_grant_next", 32'(grant_o), 32'b010);
        drain("t6_drain", 20);
`else
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (timeout_o) found++;
        end
        chk("t6_timeout_tied0", 32'(found), 32'd0);
`endif

        $display("%0d/%0d checks passed", npass, npass + nfail);
        $finish;
    end

endmodule
